// File: rtl/text_buffer_pkg.sv
// text_pkg: shared constants, FSM state type and helper functions for the
// text_buffer character store and its font ROM.
//   TXT_COLS / TXT_ROWS : screen geometry in character cells.
//   CC_*                : teletype control codes understood by the write side.
//   txt_state_t         : write-side FSM states.
//   phys_addr()         : screen (row,col) -> cell RAM address via row_offset.
//   font_bits()         : the font image, one 8-pixel glyph row per address.
package text_pkg;

    localparam int TXT_COLS = 16;
    localparam int TXT_ROWS = 16;

    localparam logic [7:0] CC_BS = 8'h08;
    localparam logic [7:0] CC_LF = 8'h0A;
    localparam logic [7:0] CC_FF = 8'h0C;
    localparam logic [7:0] CC_CR = 8'h0D;

    typedef enum logic [1:0] {
        CLEAR_ALL  = 2'd0,
        IDLE       = 2'd1,
        CLEAR_LINE = 2'd2
    } txt_state_t;

    // Scrolling never moves data: the screen row is rotated onto a physical
    // RAM row, wrapping mod 16 through the 4-bit sum.
    function automatic logic [7:0] phys_addr(input logic [3:0] row,
                                             input logic [3:0] col,
                                             input logic [3:0] off);
        logic [3:0] prow;
        prow = row + off;
        return {prow, col};
    endfunction

    // Font image, addressed {code[6:0], line[3:0]}. The space glyph is empty;
    // every other glyph row is a fixed pattern derived from code and line.
    function automatic logic [7:0] font_bits(input logic [10:0] addr);
        logic [6:0] code;
        logic [3:0] line;
        code = addr[10:4];
        line = addr[3:0];
        if (code == 7'h20) return 8'h00;
        return {code, 1'b1} ^ {line, line};
    endfunction

endpackage

// File: rtl/text_buffer_if.sv
// text_buffer_if: write byte stream, overlay glyph read bus and status.
//   wr_valid/wr_data/wr_ready : upstream byte handshake.
//   char_xy/char_line         : overlay cell index and glyph line request.
//   char_pixels               : glyph row, bit 7 = leftmost pixel.
//   cur_col/cur_row/busy      : cursor position and clear-in-progress flag.
// master = upstream/overlay side, slave = text_buffer.
interface text_buffer_if;
    logic       wr_valid;
    logic [7:0] wr_data;
    logic       wr_ready;
    logic [7:0] char_xy;
    logic [3:0] char_line;
    logic [7:0] char_pixels;
    logic [3:0] cur_col;
    logic [3:0] cur_row;
    logic       busy;

    modport master (
        output wr_valid, wr_data, char_xy, char_line,
        input  wr_ready, char_pixels, cur_col, cur_row, busy
    );

    modport slave (
        input  wr_valid, wr_data, char_xy, char_line,
        output wr_ready, char_pixels, cur_col, cur_row, busy
    );
endinterface

// File: rtl/text_buffer_font_rom.sv
// font_rom: synchronous 2048x8 glyph ROM with one registered output stage.
//   clk, rst_n : clock and asynchronous active-low reset (clears pixels).
//   code       : 7-bit character code.
//   line       : glyph line 0..15.
//   pixels     : glyph row for {code, line}, valid one clock later.
module font_rom
    import text_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic [6:0] code,
    input  logic [3:0] line,
    output logic [7:0] pixels
);

    logic [7:0] pixels_d;
    logic [7:0] pixels_q;

    always_comb begin
        pixels_d = font_bits({code, line});
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) pixels_q <= '0;
        else        pixels_q <= pixels_d;
    end

    assign pixels = pixels_q;

endmodule

// File: rtl/text_buffer.sv
// text_buffer: 16x16 character-cell store with teletype write side and a
// 2-clock glyph read port for the VGA overlay.
//   clk, rst_n : pixel clock, asynchronous active-low reset.
//   bus        : text_buffer_if slave (byte handshake, glyph read, status).
// BLANK_CODE is written by every clear; CLEAR_ON_RESET selects whether the
// block wipes the whole buffer after reset or starts straight in IDLE.
module text_buffer
    import text_pkg::*;
#(
    parameter logic [7:0] BLANK_CODE     = 8'h20,
    parameter bit         CLEAR_ON_RESET = 1'b1
) (
    input  logic          clk,
    input  logic          rst_n,
    text_buffer_if.slave  bus
);

    logic [7:0] ram [TXT_ROWS*TXT_COLS];

    txt_state_t state_q, state_d;
    logic [7:0] clr_cnt_q, clr_cnt_d;
    logic [3:0] cur_col_q, cur_col_d;
    logic [3:0] cur_row_q, cur_row_d;
    logic [3:0] row_offset_q, row_offset_d;
    logic       wr_ready_q, wr_ready_d;
    logic [7:0] rd_code_q, rd_code_d;

    logic       we;
    logic [7:0] waddr;
    logic [7:0] wdata;
    logic       nl;

    // NOTE: every signal assigned in always_comb gets a default first, so no
    // path leaves it unassigned and no latch is inferred.
    always_comb begin
        state_d      = state_q;
        clr_cnt_d    = clr_cnt_q;
        cur_col_d    = cur_col_q;
        cur_row_d    = cur_row_q;
        row_offset_d = row_offset_q;
        we           = 1'b0;
        waddr        = phys_addr(cur_row_q, cur_col_q, row_offset_q);
        wdata        = BLANK_CODE;
        nl           = 1'b0;

        case (state_q)
            CLEAR_ALL: begin
                we           = 1'b1;
                waddr        = clr_cnt_q;
                cur_col_d    = '0;
                cur_row_d    = '0;
                row_offset_d = '0;
                clr_cnt_d    = clr_cnt_q + 8'd1;
                if (clr_cnt_q == 8'hFF) state_d = IDLE;
            end

            CLEAR_LINE: begin
                // row_offset was already advanced, so screen row 15 maps to
                // the physical row that previously held screen row 0.
                we        = 1'b1;
                waddr     = phys_addr(4'hF, clr_cnt_q[3:0], row_offset_q);
                clr_cnt_d = clr_cnt_q + 8'd1;
                if (clr_cnt_q[3:0] == 4'hF) state_d = IDLE;
            end

            IDLE: begin
                if (bus.wr_valid) begin
                    if (bus.wr_data >= 8'h20 && bus.wr_data <= 8'h7E) begin
                        we    = 1'b1;
                        wdata = bus.wr_data;
                        if (cur_col_q == 4'hF) begin
                            cur_col_d = '0;
                            nl        = 1'b1;
                        end else begin
                            cur_col_d = cur_col_q + 4'd1;
                        end
                    end else begin
                        case (bus.wr_data)
                            CC_CR: cur_col_d = '0;
                            CC_LF: nl = 1'b1;
                            CC_BS: begin
                                if (cur_col_q != 4'h0) begin
                                    cur_col_d = cur_col_q - 4'd1;
                                    we        = 1'b1;
                                    waddr     = phys_addr(cur_row_q, cur_col_q - 4'd1,
                                                          row_offset_q);
                                end
                            end
                            CC_FF: begin
                                state_d      = CLEAR_ALL;
                                clr_cnt_d    = '0;
                                cur_col_d    = '0;
                                cur_row_d    = '0;
                                row_offset_d = '0;
                            end
                            default: ;
                        endcase
                    end

                    if (nl) begin
                        if (cur_row_q != 4'hF) begin
                            cur_row_d = cur_row_q + 4'd1;
                        end else begin
                            row_offset_d = row_offset_q + 4'd1;
                            state_d      = CLEAR_LINE;
                            clr_cnt_d    = '0;
                        end
                    end
                end
            end

            default: begin
                state_d   = CLEAR_ALL;
                clr_cnt_d = '0;
            end
        endcase
    end

    assign wr_ready_d = (state_d == IDLE);

    // NOTE: sequential state uses non-blocking assignments only, so every
    // flop samples its _d value from before the clock edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= CLEAR_ON_RESET ? CLEAR_ALL : IDLE;
            wr_ready_q   <= !CLEAR_ON_RESET;
            clr_cnt_q    <= '0;
            cur_col_q    <= '0;
            cur_row_q    <= '0;
            row_offset_q <= '0;
        end else begin
            state_q      <= state_d;
            wr_ready_q   <= wr_ready_d;
            clr_cnt_q    <= clr_cnt_d;
            cur_col_q    <= cur_col_d;
            cur_row_q    <= cur_row_d;
            row_offset_q <= row_offset_d;
        end
    end

    // Read stage 1: cell code through the same row rotation as writes.
    always_comb begin
        rd_code_d = ram[phys_addr(bus.char_xy[7:4], bus.char_xy[3:0], row_offset_q)];
    end

    // NOTE: the cell RAM and its read register have no reset; contents are
    // only defined after a clear. Reading in the same edge as a write
    // returns the old cell value.
    always_ff @(posedge clk) begin
        if (we) ram[waddr] <= wdata;
        rd_code_q <= rd_code_d;
    end

    // Bit 7 of a cell code is not part of the glyph address.
    logic unused_code_msb;
    assign unused_code_msb = rd_code_q[7];

    // Read stage 2: the ROM output register is the char_pixels register;
    // char_line arrives one clock after char_xy, in step with rd_code_q.
    logic [7:0] glyph_row;

    font_rom u_font_rom (
        .clk    (clk),
        .rst_n  (rst_n),
        .code   (rd_code_q[6:0]),
        .line   (bus.char_line),
        .pixels (glyph_row)
    );

    assign bus.char_pixels = glyph_row;
    assign bus.wr_ready    = wr_ready_q;
    assign bus.busy        = ~wr_ready_q;
    assign bus.cur_col     = cur_col_q;
    assign bus.cur_row     = cur_row_q;

endmodule

// File: tb/tb_text_buffer.sv
// tb_text_buffer: self-checking bench for text_buffer. A screen-level model
// (16x16 array in screen coordinates, rows shifted on scroll, busy countdown)
// is compared against the DUT every negative edge; directed sequences pin
// literal glyph values, clear lengths and asynchronous reset behaviour,
// followed by a randomized byte stream with random overlay reads.
module tb_text_buffer;
    import text_pkg::*;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    text_buffer_if bus ();

    text_buffer #(
        .BLANK_CODE     (8'h20),
        .CLEAR_ON_RESET (1'b1)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int checks = 0;
    int failures = 0;
    logic rd_manual = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model (screen coordinates) ----------------
    logic [7:0] m_scr [16][16];
    logic [3:0] m_col, m_row;
    int         m_busy;
    logic       m_v1, m_v2;
    logic [7:0] m_code1, m_pix;

    function automatic logic [7:0] glyph(input logic [7:0] code, input logic [3:0] line);
        return font_bits({code[6:0], line});
    endfunction

    task automatic m_blank_all();
        for (int r = 0; r < 16; r++)
            for (int c = 0; c < 16; c++)
                m_scr[r][c] = 8'h20;
    endtask

    task automatic m_newline();
        if (m_row < 4'd15) begin
            m_row = m_row + 4'd1;
        end else begin
            for (int r = 0; r < 15; r++)
                for (int c = 0; c < 16; c++)
                    m_scr[r][c] = m_scr[r+1][c];
            for (int c = 0; c < 16; c++) m_scr[15][c] = 8'h20;
            m_busy = 16;
        end
    endtask

    task automatic m_apply(input logic [7:0] b);
        if (b >= 8'h20 && b <= 8'h7E) begin
            m_scr[m_row][m_col] = b;
            if (m_col == 4'd15) begin
                m_col = 4'd0;
                m_newline();
            end else begin
                m_col = m_col + 4'd1;
            end
        end else if (b == CC_CR) begin
            m_col = 4'd0;
        end else if (b == CC_LF) begin
            m_newline();
        end else if (b == CC_BS) begin
            if (m_col != 4'd0) begin
                m_col = m_col - 4'd1;
                m_scr[m_row][m_col] = 8'h20;
            end
        end else if (b == CC_FF) begin
            m_blank_all();
            m_col  = 4'd0;
            m_row  = 4'd0;
            m_busy = 256;
        end
    endtask

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_col  = 4'd0;
            m_row  = 4'd0;
            m_busy = 256;
            m_v1   = 1'b0;
            m_v2   = 1'b0;
            m_pix  = 8'h00;
            m_blank_all();
        end else begin
            if (m_v1) m_pix = glyph(m_code1, bus.char_line);
            m_v2    = m_v1;
            m_v1    = (m_busy == 0);
            m_code1 = m_scr[bus.char_xy[7:4]][bus.char_xy[3:0]];
            if (m_busy > 0) m_busy--;
            else if (bus.wr_valid) m_apply(bus.wr_data);
        end
    end

    // ---------------- per-cycle compare ----------------
    always @(negedge clk) begin
        if (rst_n) begin
            check("wr_ready", bus.wr_ready, m_busy == 0);
            check("busy", bus.busy, m_busy != 0);
            check("cur_col", bus.cur_col, m_col);
            check("cur_row", bus.cur_row, m_row);
            if (m_v2) check("char_pixels", bus.char_pixels, m_pix);
        end
    end

    // Random overlay reads whenever the directed sequence is not reading.
    always @(negedge clk) begin
        if (!rd_manual) begin
            bus.char_xy   = 8'($urandom);
            bus.char_line = 4'($urandom);
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic send(input logic [7:0] b);
        int n;
        n = 0;
        bus.wr_valid = 1'b1;
        bus.wr_data  = b;
        while (bus.wr_ready !== 1'b1 && n < 1000) begin
            @(negedge clk);
            n++;
        end
        if (n >= 1000) check("send_wait", bus.wr_ready, 1);
        @(negedge clk);
        bus.wr_valid = 1'b0;
    endtask

    task automatic count_busy(output int n);
        n = 0;
        while (bus.wr_ready !== 1'b1 && n < 2000) begin
            n++;
            @(negedge clk);
        end
    endtask

    task automatic read_cell(input logic [7:0] xy, input logic [3:0] line,
                             input logic [7:0] exp, input string name);
        rd_manual = 1'b1;
        @(negedge clk);
        bus.char_xy = xy;
        @(negedge clk);
        bus.char_line = line;
        @(negedge clk);
        check(name, bus.char_pixels, exp);
        rd_manual = 1'b0;
    endtask

    initial begin
        #900000;
        $display("FAIL watchdog: simulation did not finish, checks=%0d", checks);
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        logic [7:0] b;
        int r;

        bus.wr_valid  = 1'b0;
        bus.wr_data   = 8'h00;
        bus.char_xy   = 8'h00;
        bus.char_line = 4'h0;

        repeat (3) @(negedge clk);
        check("rst_cur_col", bus.cur_col, 0);
        check("rst_cur_row", bus.cur_row, 0);
        check("rst_char_pixels", bus.char_pixels, 0);
        check("rst_wr_ready", bus.wr_ready, 0);
        check("rst_busy", bus.busy, 1);

        rst_n = 1'b1;
        count_busy(n);
        check("init_clear_len", n, 256);
        for (int i = 0; i < 256; i += 37) read_cell(8'(i), 4'(i), 8'h00, "init_blank");

        send(CC_BS);
        check("bs_at_col0_col", bus.cur_col, 0);
        check("bs_at_col0_row", bus.cur_row, 0);

        send(8'h41);
        check("A_col", bus.cur_col, 1);
        check("A_row", bus.cur_row, 0);
        read_cell(8'h00, 4'd3, 8'hB0, "A_glyph_line3");

        send(CC_BS);
        check("bs_col", bus.cur_col, 0);
        read_cell(8'h00, 4'd3, 8'h00, "bs_cell_blank");

        send(CC_CR);
        repeat (16) send(8'h42);
        check("wrap_col", bus.cur_col, 0);
        check("wrap_row", bus.cur_row, 1);
        read_cell(8'd15, 4'd0, 8'h85, "cell15_B");
        read_cell(8'd16, 4'd0, 8'h00, "cell16_blank");

        send(8'h43);
        repeat (14) send(CC_LF);
        check("pre_scroll_row", bus.cur_row, 15);
        send(CC_LF);
        count_busy(n);
        check("scroll_clear_len", n, 16);
        check("scroll_row", bus.cur_row, 15);
        check("scroll_col", bus.cur_col, 1);
        read_cell(8'h00, 4'd1, 8'h96, "scroll_row0_was_row1");
        read_cell(8'hF0, 4'd1, 8'h00, "scroll_bottom_blank");

        send(CC_FF);
        bus.wr_valid = 1'b1;
        bus.wr_data  = 8'h43;
        count_busy(n);
        check("ff_clear_len", n, 256);
        @(negedge clk);
        bus.wr_valid = 1'b0;
        check("ff_then_C_col", bus.cur_col, 1);
        check("ff_then_C_row", bus.cur_row, 0);
        read_cell(8'h00, 4'd1, 8'h96, "ff_then_C_cell0");

        for (int i = 0; i < 300; i++) begin
            r = $urandom_range(0, 99);
            if (r < 65)      b = 8'($urandom_range(8'h20, 8'h7E));
            else if (r < 72) b = CC_CR;
            else if (r < 82) b = CC_LF;
            else if (r < 92) b = CC_BS;
            else if (r < 94) b = CC_FF;
            else             b = 8'($urandom_range(8'h7F, 8'hFF));
            send(b);
            repeat ($urandom_range(0, 2)) @(negedge clk);
        end

        send(CC_CR);
        repeat (16) send(CC_LF);
        send(8'h41);
        send(CC_LF);
        repeat (3) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("async_rst_col", bus.cur_col, 0);
        check("async_rst_row", bus.cur_row, 0);
        check("async_rst_pixels", bus.char_pixels, 0);
        check("async_rst_ready", bus.wr_ready, 0);
        check("async_rst_busy", bus.busy, 1);
        @(negedge clk);
        rst_n = 1'b1;
        count_busy(n);
        check("rst_reclear_len", n, 256);
        read_cell(8'h55, 4'd2, 8'h00, "post_reset_blank");
        send(8'h5A);
        check("post_reset_write_col", bus.cur_col, 1);
        repeat (4) @(negedge clk);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
